shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
Command-driven sequencer for the team's serial shift_register block. It accepts a word, a shift direction and a bit count over a valid/ready command port. It then drives the shift register's d/en/dir inputs for exactly that many clocks, captures the register's parallel output, and returns it on a valid/ready response port. It sits between a bus-side master and one shift_register instance, so software-level code never has to toggle en/dir cycle by cycle.

Parameters:
WIDTH, 32, shift register width and command/response data width
CNT_W, $clog2(WIDTH+1), width of the bit-count field

Ports:
clk_i  input  1  clock, all state on rising edge
rstn_i  input  1  reset, asynchronous, active-low
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command ready
cmd_dir_i  input  1  0 = shift left (d enters bit 0), 1 = shift right (d enters bit WIDTH-1)
cmd_len_i  input  CNT_W  number of bits to shift
cmd_data_i  input  WIDTH  serial source word, sent LSB first
sr_d_o  output  1  to shift_register d_i
sr_en_o  output  1  to shift_register en_i
sr_dir_o  output  1  to shift_register dir_i
sr_q_i  input  WIDTH  from shift_register reg_o
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response ready
rsp_data_o  output  WIDTH  captured shift register contents
busy_o  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, SHIFT, SETTLE, RESP. State, counter and latched command are registers; outputs are decoded from them.
- Reset (async, rstn_i low): state = IDLE, counter = 0, latched data/dir/len = 0, rsp_data_o = 0. All outputs = 0 except cmd_ready_o = 1.
- Reset mid-operation aborts immediately. The shift register is left with partial contents; no response is produced.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i & cmd_ready_o, latch data/dir/len and clear the counter.
  - len = 0: go to SETTLE. Otherwise go to SHIFT.
- Length saturation: len > WIDTH saturates to WIDTH.
- SHIFT:
  - sr_en_o = 1; sr_d_o = latched_data[counter]; sr_dir_o = latched dir.
  - Counter increments each clock.
  - On the clock where counter == len-1, go to SETTLE. Exactly len enabled cycles occur.
- SETTLE:
  - sr_en_o = 0 and sr_dir_o is still held.
  - sr_q_i now reflects the final shift. Capture it into rsp_data_o on the exiting edge, then go to RESP.
- RESP:
  - rsp_valid_o = 1; rsp_data_o is stable and held until rsp_ready_i.
  - On rsp_valid_o & rsp_ready_i, go to IDLE.
- Latency: rsp_valid_o rises len+2 clocks after the command-accept edge (2 clocks for len = 0).
- cmd_ready_o = 0 outside IDLE; commands presented while busy are held off, not dropped.
- Back-to-back commands: there is a minimum of one IDLE cycle between the response handshake and the next accept.
- sr_en_o = 0 and sr_d_o = 0 in IDLE, SETTLE and RESP. sr_dir_o = 0 in IDLE.
- rsp_valid_o held with rsp_ready_i low: state and data are frozen indefinitely.
- The block does not clear the shift register; contents accumulate across commands.
- Counter width: CNT_W. Indexing latched_data with counter never exceeds WIDTH-1, guaranteed by the length saturation.

Test Plan:
Shift register reg_o starts at 0 after reset in every case.
- Reset: WIDTH=8, hold rstn_i low 2 clocks -> all outputs 0, cmd_ready_o = 1, busy_o = 0.
- Left shift: dir=0, len=8, data=0x0F -> sr_en_o high exactly 8 cycles, sr_d_o sequence 1,1,1,1,0,0,0,0; rsp_valid_o 10 clocks after accept; rsp_data_o = 0xF0.
- Right shift: after reset, dir=1, len=8, data=0x0F -> rsp_data_o = 0x0F.
- Partial length plus backpressure:
  - After reset, dir=0, len=4, data=0x0F, rsp_ready_i low 5 cycles -> rsp_data_o = 0x0F, held stable with rsp_valid_o high through the stall.
  - A second command presented during the stall is not accepted until 1 cycle after the response handshake.
- Boundaries:
  - len=0 -> no sr_en_o pulse; rsp_valid_o after 2 clocks; rsp_data_o = current sr_q_i.
  - len=15 with WIDTH=8 -> exactly 8 enabled cycles.
- Mid-operation reset: assert rstn_i low on the 3rd SHIFT cycle -> sr_en_o drops asynchronously, no rsp_valid_o, block returns to IDLE with cmd_ready_o = 1.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
//
// Command-driven sequencer for a serial shift_register instance. A command
// carries a word, a shift direction and a bit count. The block feeds the word
// LSB first into the shift register's d input with en held high for exactly
// that many clocks. It then captures the register's parallel output and
// returns it on a valid/ready response port.
//
// Parameters:
//   WIDTH  shift register width and command/response data width
//   CNT_W  width of the bit-count field ($clog2(WIDTH+1))
//
// Ports:
//   clk_i        clock, all state on rising edge
//   rstn_i       asynchronous active-low reset
//   cmd_valid_i  command valid
//   cmd_ready_o  command ready (high only in IDLE)
//   cmd_dir_i    0 = shift left (d enters bit 0), 1 = shift right (d enters MSB)
//   cmd_len_i    number of bits to shift (values above WIDTH saturate)
//   cmd_data_i   serial source word, sent LSB first
//   sr_d_o       to shift_register d_i
//   sr_en_o      to shift_register en_i
//   sr_dir_o     to shift_register dir_i
//   sr_q_i       from shift_register reg_o
//   rsp_valid_o  response valid
//   rsp_ready_i  response ready
//   rsp_data_o   captured shift register contents
//   busy_o       high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_dir_i,
    input  logic [CNT_W-1:0] cmd_len_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    output logic             sr_d_o,
    output logic             sr_en_o,
    output logic             sr_dir_o,
    input  logic [WIDTH-1:0] sr_q_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             busy_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_sat;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_shifted;
    logic             dir_q;
    logic             cmd_fire;
    logic             rsp_fire;
    logic             last_shift;

    // Lengths beyond the register width saturate, which also keeps the
    // counter from ever selecting a bit past WIDTH-1 of the latched word.
    assign len_sat = (cmd_len_i > LEN_MAX) ? LEN_MAX : cmd_len_i;

    assign cmd_fire   = cmd_valid_i & cmd_ready_o;
    assign rsp_fire   = rsp_valid_o & rsp_ready_i;
    assign last_shift = (state == ST_SHIFT) && (count == (len_q - CNT_ONE));

    // Shifting the word down by the counter presents the current serial bit
    // at position 0 without a variable-width bit select.
    assign data_shifted = data_q >> count;

    // Next-state decode. A zero-length command skips SHIFT entirely so the
    // register is never enabled, but still passes through SETTLE so the
    // response carries a fresh capture of sr_q_i.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_nxt = (len_sat == '0) ? ST_SETTLE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_shift) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_fire) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command latch and bit counter. The counter clears on accept and
    // advances once per enabled cycle; its value after the last shift is
    // never used.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count  <= '0;
            len_q  <= '0;
            data_q <= '0;
            dir_q  <= 1'b0;
        end else if (cmd_fire) begin
            count  <= '0;
            len_q  <= len_sat;
            data_q <= cmd_data_i;
            dir_q  <= cmd_dir_i;
        end else if (state == ST_SHIFT) begin
            count  <= count + CNT_ONE;
        end
    end

    // Response capture. SETTLE is the first cycle in which sr_q_i shows the
    // result of the final shift, so the capture happens on its exiting edge
    // and the value is then held untouched through any response stall.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rsp_data_o <= '0;
        end else if (state == ST_SETTLE) begin
            rsp_data_o <= sr_q_i;
        end
    end

    // Output decode. Everything is derived from registered state, so an
    // asynchronous reset removes the enable immediately.
    always_comb begin
        cmd_ready_o = (state == ST_IDLE);
        busy_o      = (state != ST_IDLE);
        rsp_valid_o = (state == ST_RESP);
        sr_en_o     = (state == ST_SHIFT);
        sr_d_o      = (state == ST_SHIFT) & data_shifted[0];
        sr_dir_o    = (state != ST_IDLE) & dir_q;
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_ctrl
//
// Self-checking bench for shift_seq_ctrl at WIDTH=8. A simple shift register
// model sits on the sr_* port. Expected responses come from an arithmetic
// model of what N serial bits do to a register, tracked across commands.
// ---------------------------------------------------------------------------
module tb_shift_seq_ctrl;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_dir;
    logic [CW-1:0] cmd_len;
    logic [W-1:0]  cmd_data;
    logic          sr_d;
    logic          sr_en;
    logic          sr_dir;
    logic [W-1:0]  sr_q;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          busy;

    int checks;
    int errors;
    logic [W-1:0] model_reg;

    typedef struct {
        string         name;
        bit            dir;
        int            len;
        logic [W-1:0]  data;
        int            stall;
        logic [W-1:0]  exp_data;
        int            exp_en;
    } vec_t;

    vec_t vecs[$];

    shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_dir_i   (cmd_dir),
        .cmd_len_i   (cmd_len),
        .cmd_data_i  (cmd_data),
        .sr_d_o      (sr_d),
        .sr_en_o     (sr_en),
        .sr_dir_o    (sr_dir),
        .sr_q_i      (sr_q),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift register attached to the sequencer; cleared with the same reset
    // so every test starts from an empty register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_q <= '0;
        end else if (sr_en) begin
            sr_q <= sr_dir ? {sr_d, sr_q[W-1:1]} : {sr_q[W-2:0], sr_d};
        end
    end

    // Result of feeding the first n bits of data (LSB first) into a register
    // holding start: bit i of data lands n-1-i places above bit 0 for a left
    // shift, or i places above bit W-n for a right shift.
    function automatic logic [W-1:0] model_shift(input logic [W-1:0] start, input bit dir,
                                                 input int len, input logic [W-1:0] data);
        int n;
        int acc;
        n = (len > W) ? W : len;
        if (!dir) begin
            acc = (int'(start) << n) & ((1 << W) - 1);
            for (int i = 0; i < n; i++) acc = acc | (int'(data[i]) << (n - 1 - i));
        end else begin
            acc = int'(start) >> n;
            for (int i = 0; i < n; i++) acc = acc | (int'(data[i]) << (W - n + i));
        end
        return acc[W-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_len   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        model_reg = '0;
    endtask

    // Presents a command and returns at the negedge just after it was
    // accepted, i.e. in the first cycle after the handshake.
    task automatic applyStimulus(input bit dir, input int len, input logic [W-1:0] data);
        int waited;
        waited    = 0;
        cmd_dir   = dir;
        cmd_len   = CW'(len);
        cmd_data  = data;
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("cmd_accept_in_time", 32'(waited < 50), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Waits for rsp_valid; lat counts cycles after the handshake cycle.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput({tag, "_idle_after"}, {29'd0, cmd_ready, busy, rsp_valid}, 32'b100);
    endtask

    // Full command: drive, watch the serial side, check latency and data,
    // stall the response, then complete the handshake.
    task automatic run_cmd(input string tag, input bit dir, input int len, input logic [W-1:0] data,
                           input int stall, output logic [W-1:0] got, output int en_cnt);
        int n;
        int lat;
        int d_bad;
        int dir_bad;
        int hold_bad;
        logic [W-1:0] exp;
        logic [W-1:0] held;
        n       = (len > W) ? W : len;
        exp     = model_shift(model_reg, dir, len, data);
        en_cnt  = 0;
        d_bad   = 0;
        dir_bad = 0;
        applyStimulus(dir, len, data);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            if (sr_en) begin
                if (en_cnt >= W || sr_d !== data[en_cnt]) d_bad++;
                if (sr_dir !== dir) dir_bad++;
                en_cnt++;
            end else if (sr_d !== 1'b0) begin
                d_bad++;
            end
            @(negedge clk);
            lat++;
        end
        got = rsp_data;
        checkOutput({tag, "_latency"}, lat, n + 2);
        checkOutput({tag, "_en_cycles"}, en_cnt, n);
        checkOutput({tag, "_d_seq_errs"}, d_bad, 0);
        checkOutput({tag, "_dir_errs"}, dir_bad, 0);
        checkOutput({tag, "_rsp_data"}, rsp_data, exp);
        held     = rsp_data;
        hold_bad = 0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0 || sr_en !== 1'b0)
                hold_bad++;
        end
        checkOutput({tag, "_stall_hold_errs"}, hold_bad, 0);
        handshake_rsp(tag);
        model_reg = exp;
    endtask

    initial begin
        logic [W-1:0] got;
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
        int en_cnt;
        int lat;
        int bad;

        checks = 0;
        errors = 0;
        rstn   = 1'b0;

        // Reset values, sampled while reset is still held.
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_dir   = 1'b0;
        cmd_len   = '0;
        cmd_data  = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs",
                    {25'd0, cmd_ready, busy, rsp_valid, sr_en, sr_d, sr_dir, 1'b0}, 32'b1000000);
        checkOutput("reset_rsp_data", rsp_data, 0);
        reset_dut();

        // Test-plan vectors; each starts from an empty register.
        vecs.push_back('{"left8",      1'b0, 8,  8'h0F, 0, 8'hF0, 8});
        vecs.push_back('{"right8",     1'b1, 8,  8'h0F, 0, 8'h0F, 8});
        vecs.push_back('{"left4_bp",   1'b0, 4,  8'h0F, 5, 8'h0F, 4});
        vecs.push_back('{"len0",       1'b0, 0,  8'hFF, 0, 8'h00, 0});
        vecs.push_back('{"len15_sat",  1'b0, 15, 8'h0F, 0, 8'hF0, 8});
        vecs.push_back('{"right3",     1'b1, 3,  8'h05, 1, 8'hA0, 3});
        vecs.push_back('{"left5",      1'b0, 5,  8'h16, 2, 8'h0D, 5});
        foreach (vecs[i]) begin
            reset_dut();
            run_cmd(vecs[i].name, vecs[i].dir, vecs[i].len, vecs[i].data, vecs[i].stall, got, en_cnt);
            checkOutput({vecs[i].name, "_tbl_data"}, got, vecs[i].exp_data);
            checkOutput({vecs[i].name, "_tbl_en"}, en_cnt, vecs[i].exp_en);
        end

        // Second command held off during a response stall, accepted in the
        // cycle right after the response handshake.
        reset_dut();
        exp_a = model_shift(model_reg, 1'b0, 4, 8'h0F);
        applyStimulus(1'b0, 4, 8'h0F);
        wait_rsp(lat);
        checkOutput("bp_latency", lat, 6);
        cmd_dir   = 1'b1;
        cmd_len   = CW'(2);
        cmd_data  = 8'h03;
        cmd_valid = 1'b1;
        for (int s = 0; s < 5; s++) begin
            checkOutput("bp_hold_state", {29'd0, rsp_valid, cmd_ready, busy}, 32'b101);
            checkOutput("bp_hold_data", rsp_data, exp_a);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("bp_idle_gap", {30'd0, cmd_ready, busy}, 32'b10);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("bp_second_accepted", {30'd0, cmd_ready, busy}, 32'b01);
        model_reg = exp_a;
        exp_b = model_shift(model_reg, 1'b1, 2, 8'h03);
        wait_rsp(lat);
        checkOutput("bp_second_latency", lat, 4);
        checkOutput("bp_second_data", rsp_data, exp_b);
        handshake_rsp("bp_second");
        model_reg = exp_b;

        // Reset on the third SHIFT cycle aborts without a response.
        reset_dut();
        applyStimulus(1'b0, 8, 8'hFF);
        repeat (2) @(negedge clk);
        checkOutput("midrst_shifting", sr_en, 1);
        #2 rstn = 1'b0;
        #1;
        checkOutput("midrst_async_outputs", {28'd0, sr_en, busy, rsp_valid, cmd_ready}, 32'b0001);
        @(negedge clk);
        rstn = 1'b1;
        bad  = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (rsp_valid || busy || sr_en) bad++;
        end
        checkOutput("midrst_no_response", bad, 0);
        checkOutput("midrst_ready", cmd_ready, 1);

        // Random commands with accumulation across commands.
        reset_dut();
        for (int k = 0; k < 40; k++) begin
            run_cmd("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                    W'($urandom), $urandom_range(0, 3), got, en_cnt);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
